mby_egr_tagring_rx: RTL
=======================

Name: mby_egr_tagring_rx

Overview:
- Parametrised egress tag-ring receiver. It replaces the flat single-struct tag-ring hookup with a registered, filtered, per-port buffered endpoint.
- It snoops the tag ring and accepts slots addressed to this EGR instance. Accepted tags are stored in NUM_PORTS independent FIFOs.
- Each FIFO presents its tags to the egress scheduler over a valid/ready handshake.
- Per-port XOFF back-pressure goes to the ring, and saturating drop counters and an error flag go to CSR.

Parameters:
- NUM_PORTS, 4, number of egress ports / FIFOs (power of 2, 2..16).
- TAG_W, 64, tag payload width in bits.
- DEPTH, 8, entries per port FIFO (power of 2, 2..64).
- EGR_ID_W, 4, width of ring EGR destination id.
- CNT_W, 16, drop counter width.

Ports:
- cclk  in  1  core clock.
- rst_n  in  1  synchronous active-low reset.
- ring_vld  in  1  tag-ring slot valid.
- ring_egr_id  in  EGR_ID_W  destination EGR id of slot.
- ring_dst_port  in  PW=$clog2(NUM_PORTS)+1  destination port in slot; MSB set means out of range.
- ring_tag  in  TAG_W  tag payload.
- cfg_egr_id  in  EGR_ID_W  this instance's id, static after reset.
- cfg_xoff_thresh  in  $clog2(DEPTH)+1  fill level at which XOFF asserts.
- tag_vld  out  NUM_PORTS  per-port head-of-FIFO valid.
- tag_data  out  NUM_PORTS*TAG_W  per-port head tag; port p occupies bits [p*TAG_W +: TAG_W].
- tag_rdy  in  NUM_PORTS  per-port consumer ready.
- xoff  out  NUM_PORTS  per-port back-pressure to ring.
- drop_cnt  out  NUM_PORTS*CNT_W  per-port saturating drop count.
- err_bad_dst  out  1  sticky: a matching slot carried an out-of-range port.

Behaviour:

Reset:
- While rst_n=0 on a cclk edge, all FIFOs are emptied and the input register is cleared.
- Reset values: tag_vld=0, tag_data=0, xoff=0, drop_cnt=0, err_bad_dst=0.
- Reset mid-operation discards all stored tags. No partial pops are reported.

Stage 0 (input register):
- ring_vld, ring_egr_id, ring_dst_port and ring_tag are flopped unconditionally into s0_*.

Stage 1 (accept):
- hit = s0_vld && s0_egr_id==cfg_egr_id.
- If hit and s0_dst_port >= NUM_PORTS: the tag is discarded and err_bad_dst is set. err_bad_dst is cleared only by reset.
- If hit and in range: the tag is pushed into FIFO[s0_dst_port].
- Slots that do not hit are ignored silently.

FIFO (per port):
- Circular buffer with wr_ptr, rd_ptr and count (0..DEPTH). Pointers wrap modulo DEPTH.
- Output is first-word-fall-through: tag_vld[p] = (count!=0), and tag_data[p] = mem[rd_ptr], zeroed when empty.
- Pop occurs when tag_vld[p] && tag_rdy[p]. Asserting tag_rdy while empty has no effect.
- Push with count<DEPTH: the write is accepted.
- Push with count==DEPTH and a simultaneous pop: the write is accepted and count stays DEPTH.
- Push with count==DEPTH and no pop: the tag is dropped and drop_cnt[p] increments, saturating at 2^CNT_W-1.
- count update per cycle: +1 push only, -1 pop only, unchanged for both or neither.

Latency:
- A ring slot at edge N appears on tag_vld/tag_data after edge N+2 if its FIFO was empty (1 input flop + 1 FIFO write).

XOFF:
- Registered: xoff[p] <= (count_next[p] >= cfg_xoff_thresh).
- cfg_xoff_thresh=0 forces xoff=1 permanently after reset.
- cfg_xoff_thresh > DEPTH means xoff never asserts.
- The ring honours xoff with up to 3 cycles of skid. Setting cfg_xoff_thresh <= DEPTH-3 is therefore required for lossless operation.

Ordering:
- Tags within a port are strictly in arrival order. Ports are independent.

Test Plan:
- Reset then idle: all outputs read 0. Drive ring_vld=1 with ring_egr_id != cfg_egr_id for 10 cycles: tag_vld stays 0 and drop_cnt stays 0.
- cfg_egr_id=3, one slot at edge N with id=3, port=2, tag=0xDEAD_BEEF, tag_rdy=0: tag_vld[2]=1 after edge N+2 with data 0xDEAD_BEEF. Assert tag_rdy[2] one cycle: tag_vld[2]=0 next cycle.
- DEPTH=8, tag_rdy[1]=0, push 11 tags 1..11 to port 1: tags 1..8 are held and drop_cnt[1]=3. Draining yields 1..8 in order, including across the pointer wrap.
- Port 0 full with tag_rdy[0]=1 and a push in the same cycle: count stays 8, drop_cnt[0] stays 0, the new tag is last out.
- cfg_xoff_thresh=5: after the 5th push xoff[p] rises one cycle later. It falls one cycle after the pop that brings count to 4.
- Matching slot with port=NUM_PORTS+1: err_bad_dst=1 and stays set; no FIFO changes. Pulse rst_n=0 with tags queued in 3 ports: everything clears on the next edge.

Source files
------------

// File: rtl/mby_egr_tagring_rx.sv
// ----------------------------------------------------------------------------
// mby_egr_tagring_rx
//
// Egress tag-ring receiver. Snoops the tag ring, keeps the slots addressed to
// this EGR instance and buffers them in one FIFO per egress port. Each FIFO
// feeds the egress scheduler over a first-word-fall-through valid/ready
// interface.
//
// Ports:
//   cclk, rst_n          core clock, synchronous active-low reset
//   ring_*               tag-ring slot (valid, EGR id, dst port, tag)
//   cfg_egr_id           this instance's ring id (static after reset)
//   cfg_xoff_thresh      FIFO fill level at which xoff asserts
//   tag_vld/tag_data     per-port head of FIFO (port p at [p*TAG_W +: TAG_W])
//   tag_rdy              per-port consumer ready (pop = tag_vld & tag_rdy)
//   xoff                 per-port registered back-pressure to the ring
//   drop_cnt             per-port saturating count of tags lost to a full FIFO
//   err_bad_dst          sticky: a matching slot carried an out-of-range port
// ----------------------------------------------------------------------------
module mby_egr_tagring_rx #(
    parameter int NUM_PORTS = 4,
    parameter int TAG_W     = 64,
    parameter int DEPTH     = 8,
    parameter int EGR_ID_W  = 4,
    parameter int CNT_W     = 16,
    localparam int PW       = $clog2(NUM_PORTS) + 1,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic                       cclk,
    input  logic                       rst_n,
    input  logic                       ring_vld,
    input  logic [EGR_ID_W-1:0]        ring_egr_id,
    input  logic [PW-1:0]              ring_dst_port,
    input  logic [TAG_W-1:0]           ring_tag,
    input  logic [EGR_ID_W-1:0]        cfg_egr_id,
    input  logic [CW-1:0]              cfg_xoff_thresh,
    output logic [NUM_PORTS-1:0]       tag_vld,
    output logic [NUM_PORTS*TAG_W-1:0] tag_data,
    input  logic [NUM_PORTS-1:0]       tag_rdy,
    output logic [NUM_PORTS-1:0]       xoff,
    output logic [NUM_PORTS*CNT_W-1:0] drop_cnt,
    output logic                       err_bad_dst
);

    localparam int AW = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Stage 0: unconditional input register
    // ------------------------------------------------------------------
    logic                s0_vld_q,      s0_vld_d;
    logic [EGR_ID_W-1:0] s0_egr_id_q,   s0_egr_id_d;
    logic [PW-1:0]       s0_dst_port_q, s0_dst_port_d;
    logic [TAG_W-1:0]    s0_tag_q,      s0_tag_d;
    logic                err_bad_dst_q, err_bad_dst_d;

    logic hit;
    logic good_hit;

    always_comb begin
        s0_vld_d      = ring_vld;
        s0_egr_id_d   = ring_egr_id;
        s0_dst_port_d = ring_dst_port;
        s0_tag_d      = ring_tag;

        // NUM_PORTS is a power of two, so the port MSB alone marks out-of-range.
        hit           = s0_vld_q && (s0_egr_id_q == cfg_egr_id);
        good_hit      = hit && !s0_dst_port_q[PW-1];
        err_bad_dst_d = err_bad_dst_q | (hit && s0_dst_port_q[PW-1]);
    end

    always_ff @(posedge cclk) begin
        if (!rst_n) begin
            s0_vld_q      <= 1'b0;
            s0_egr_id_q   <= '0;
            s0_dst_port_q <= '0;
            s0_tag_q      <= '0;
            err_bad_dst_q <= 1'b0;
        end else begin
            s0_vld_q      <= s0_vld_d;
            s0_egr_id_q   <= s0_egr_id_d;
            s0_dst_port_q <= s0_dst_port_d;
            s0_tag_q      <= s0_tag_d;
            err_bad_dst_q <= err_bad_dst_d;
        end
    end

    assign err_bad_dst = err_bad_dst_q;

    // ------------------------------------------------------------------
    // Stage 1: per-port FIFOs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        logic [TAG_W-1:0] mem [DEPTH];
        logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
        logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
        logic [CW-1:0]    count_q,  count_d;
        logic [CNT_W-1:0] drop_q,   drop_d;
        logic             xoff_q,   xoff_d;
        logic             push, pop, full, wr_en, drop;

        always_comb begin
            push  = good_hit && (s0_dst_port_q[PW-2:0] == (PW-1)'(gi));
            pop   = (count_q != '0) && tag_rdy[gi];
            full  = (count_q == CW'(DEPTH));
            // A full FIFO still accepts when its head leaves in the same cycle.
            wr_en = push && (!full || pop);
            drop  = push && full && !pop;

            wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;

            count_d = count_q;
            if (wr_en && !pop) begin
                count_d = count_q + CW'(1);
            end else if (!wr_en && pop) begin
                count_d = count_q - CW'(1);
            end

            drop_d = drop_q;
            if (drop && (drop_q != '1)) begin
                drop_d = drop_q + CNT_W'(1);
            end

            xoff_d = (count_d >= cfg_xoff_thresh);
        end

        always_ff @(posedge cclk) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                drop_q   <= '0;
                xoff_q   <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                drop_q   <= drop_d;
                xoff_q   <= xoff_d;
            end
        end

        // Storage needs no reset: emptiness is tracked by count_q alone.
        always_ff @(posedge cclk) begin
            if (wr_en) begin
                mem[wr_ptr_q] <= s0_tag_q;
            end
        end

        // Fall-through head: the read is combinational so the head tag is
        // visible in the same cycle tag_vld rises.
        assign tag_vld[gi]                  = (count_q != '0);
        assign tag_data[gi*TAG_W +: TAG_W]  = (count_q != '0) ? mem[rd_ptr_q] : '0;
        assign xoff[gi]                     = xoff_q;
        assign drop_cnt[gi*CNT_W +: CNT_W]  = drop_q;
    end

endmodule
